// File: rtl/game_engine.sv
// Sokoban move engine: loads a level from the init stage, then executes one
// direction command per two cycles with wall/box/edge checks and win detection.
module game_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_game,
  input  logic [1:0]   level_sel,
  output logic [1:0]   stage,
  input  logic [63:0]  wall,
  input  logic [63:0]  destination,
  input  logic [163:0] game_state_int,
  input  logic         dir_valid,
  input  logic [1:0]   dir,
  output logic         dir_ready,
  output logic [63:0]  box,
  output logic [2:0]   player_x,
  output logic [2:0]   player_y,
  output logic [9:0]   moves,
  output logic [9:0]   pushes,
  output logic         step_done,
  output logic         moved,
  output logic         win
);

  typedef enum logic [1:0] {LOAD, PLAY, EVAL, WON} state_t;

  state_t      state_q, state_d;
  logic [1:0]  stage_q, stage_d;
  logic [63:0] box_q, box_d;
  logic [2:0]  px_q, px_d, py_q, py_d;
  logic [9:0]  moves_q, moves_d, pushes_q, pushes_d;
  logic        step_done_q, step_done_d;
  logic        moved_q, moved_d;
  logic        win_q, win_d;
  logic        t_off_q, t_off_d, b_off_q, b_off_d;
  logic [5:0]  t_idx_q, t_idx_d, b_idx_q, b_idx_d;

  logic [2:0]  tx, ty, bx, by;
  logic        t_off, b_off;
  logic        is_push, blocked;
  logic [63:0] box_step;
  logic        win_cond;

  logic unused_state_bits;
  assign unused_state_bits = ^game_state_int[163:70];

  // Neighbour coordinates; 3-bit wrap is harmless because the off-board flags mask it.
  always_comb begin
    tx    = px_q;
    ty    = py_q;
    bx    = px_q;
    by    = py_q;
    t_off = 1'b0;
    b_off = 1'b0;
    case (dir)
      2'd0: begin
        ty    = py_q - 3'd1;
        by    = py_q - 3'd2;
        t_off = (py_q == 3'd0);
        b_off = (py_q <= 3'd1);
      end
      2'd1: begin
        ty    = py_q + 3'd1;
        by    = py_q + 3'd2;
        t_off = (py_q == 3'd7);
        b_off = (py_q >= 3'd6);
      end
      2'd2: begin
        tx    = px_q - 3'd1;
        bx    = px_q - 3'd2;
        t_off = (px_q == 3'd0);
        b_off = (px_q <= 3'd1);
      end
      default: begin
        tx    = px_q + 3'd1;
        bx    = px_q + 3'd2;
        t_off = (px_q == 3'd7);
        b_off = (px_q >= 3'd6);
      end
    endcase
  end

  always_comb begin
    is_push  = box_q[t_idx_q];
    blocked  = t_off_q | wall[t_idx_q] |
               (is_push & (b_off_q | wall[b_idx_q] | box_q[b_idx_q]));
    box_step = box_q;
    if (!blocked && is_push) begin
      box_step[t_idx_q] = 1'b0;
      box_step[b_idx_q] = 1'b1;
    end
    win_cond = ((box_step & ~destination) == '0) && (box_step != '0);
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    box_d       = box_q;
    px_d        = px_q;
    py_d        = py_q;
    moves_d     = moves_q;
    pushes_d    = pushes_q;
    step_done_d = 1'b0;
    moved_d     = moved_q;
    win_d       = win_q;
    t_off_d     = t_off_q;
    b_off_d     = b_off_q;
    t_idx_d     = t_idx_q;
    b_idx_d     = b_idx_q;

    if (new_game) begin
      stage_d = level_sel;
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          box_d    = game_state_int[69:6];
          px_d     = game_state_int[5:3];
          py_d     = game_state_int[2:0];
          moves_d  = '0;
          pushes_d = '0;
          win_d    = 1'b0;
          state_d  = PLAY;
        end
        PLAY: begin
          if (dir_valid) begin
            t_off_d = t_off;
            b_off_d = b_off;
            t_idx_d = {ty, tx};
            b_idx_d = {by, bx};
            state_d = EVAL;
          end
        end
        EVAL: begin
          step_done_d = 1'b1;
          moved_d     = ~blocked;
          if (!blocked) begin
            box_d   = box_step;
            px_d    = t_idx_q[2:0];
            py_d    = t_idx_q[5:3];
            moves_d = (moves_q == '1) ? moves_q : moves_q + 10'd1;
            if (is_push)
              pushes_d = (pushes_q == '1) ? pushes_q : pushes_q + 10'd1;
          end
          win_d   = win_cond;
          state_d = win_cond ? WON : PLAY;
        end
        default: begin
          state_d = WON;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      stage_q     <= '0;
      box_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      moves_q     <= '0;
      pushes_q    <= '0;
      step_done_q <= 1'b0;
      moved_q     <= 1'b0;
      win_q       <= 1'b0;
      t_off_q     <= 1'b0;
      b_off_q     <= 1'b0;
      t_idx_q     <= '0;
      b_idx_q     <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      box_q       <= box_d;
      px_q        <= px_d;
      py_q        <= py_d;
      moves_q     <= moves_d;
      pushes_q    <= pushes_d;
      step_done_q <= step_done_d;
      moved_q     <= moved_d;
      win_q       <= win_d;
      t_off_q     <= t_off_d;
      b_off_q     <= b_off_d;
      t_idx_q     <= t_idx_d;
      b_idx_q     <= b_idx_d;
    end
  end

  assign dir_ready = (state_q == PLAY) & ~new_game;
  assign stage     = stage_q;
  assign box       = box_q;
  assign player_x  = px_q;
  assign player_y  = py_q;
  assign moves     = moves_q;
  assign pushes    = pushes_q;
  assign step_done = step_done_q;
  assign moved     = moved_q;
  assign win       = win_q;

endmodule

// File: tb/tb_game_engine.sv
// Scoreboard bench for game_engine: stimulus queues hand-computed step results,
// a negedge monitor pops and compares them whenever step_done pulses.
module tb_game_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         new_game = 1'b0;
  logic [1:0]   level_sel = '0;
  logic [1:0]   stage;
  logic [63:0]  wall, destination;
  logic [163:0] game_state_int;
  logic         dir_valid = 1'b0;
  logic [1:0]   dir = '0;
  logic         dir_ready;
  logic [63:0]  box;
  logic [2:0]   player_x, player_y;
  logic [9:0]   moves, pushes;
  logic         step_done, moved, win;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [63:0] B0   = 64'h0000_1004_2800_0000;
  localparam logic [63:0] B0P  = 64'h0010_0004_2800_0000;
  localparam logic [63:0] B1   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] W0   = 64'h1000_0020_0000_0000;

  typedef struct packed {
    logic        mvd;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [9:0]  mv;
    logic [9:0]  pu;
    logic        w;
    logic [63:0] b;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Level tables standing in for the combinational init stage.
  always_comb begin
    case (stage)
      2'd0: begin
        wall = W0; destination = 64'hF;
        game_state_int = {30'b0, 64'hFFFF_FFFF_FFFF_FFFF, B0, 3'd4, 3'd4};
      end
      2'd2: begin
        wall = '0; destination = 64'h4;
        game_state_int = {30'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 3'd0, 3'd0};
      end
      default: begin
        wall = '0; destination = '0;
        game_state_int = {30'b0, 64'hFFFF_FFFF_FFFF_FFFF, B1, 3'd2, 3'd2};
      end
    endcase
  end

  game_engine dut (
    .clk(clk), .rst(rst), .new_game(new_game), .level_sel(level_sel),
    .stage(stage), .wall(wall), .destination(destination),
    .game_state_int(game_state_int), .dir_valid(dir_valid), .dir(dir),
    .dir_ready(dir_ready), .box(box), .player_x(player_x), .player_y(player_y),
    .moves(moves), .pushes(pushes), .step_done(step_done), .moved(moved), .win(win)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic m, input logic [2:0] x, input logic [2:0] y,
                              input logic [9:0] mv, input logic [9:0] pu,
                              input logic w, input logic [63:0] b);
    exp_t e;
    e.mvd = m; e.x = x; e.y = y; e.mv = mv; e.pu = pu; e.w = w; e.b = b;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (step_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_step", {63'b0, step_done}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("moved", {63'b0, moved}, {63'b0, e.mvd});
          chk("player_x", {61'b0, player_x}, {61'b0, e.x});
          chk("player_y", {61'b0, player_y}, {61'b0, e.y});
          chk("moves", {54'b0, moves}, {54'b0, e.mv});
          chk("pushes", {54'b0, pushes}, {54'b0, e.pu});
          chk("win", {63'b0, win}, {63'b0, e.w});
          chk("box", box, e.b);
        end
      end
    end
  end

  task automatic cmd(input logic [1:0] d, input exp_t e);
    int unsigned n = 0;
    @(negedge clk);
    while (!dir_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!dir_ready) begin
      chk("ready_timeout", {63'b0, dir_ready}, 64'd1);
      return;
    end
    sb.push_back(e);
    dir_valid = 1'b1;
    dir = d;
    @(posedge clk);
    #1 dir_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1 chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic load(input logic [1:0] l, input logic [2:0] x, input logic [2:0] y,
                      input logic [63:0] b);
    @(negedge clk);
    new_game = 1'b1;
    level_sel = l;
    @(posedge clk);
    #1 new_game = 1'b0;
    chk("ld_stage", {62'b0, stage}, {62'b0, l});
    chk("ld_ready_low", {63'b0, dir_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("ld_x", {61'b0, player_x}, {61'b0, x});
    chk("ld_y", {61'b0, player_y}, {61'b0, y});
    chk("ld_box", box, b);
    chk("ld_moves", {54'b0, moves}, 64'd0);
    chk("ld_win", {63'b0, win}, 64'd0);
    chk("ld_ready", {63'b0, dir_ready}, 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [2:0] yy;
    logic [9:0] mm;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_box", box, 64'd0);
    chk("rst_xy", {58'b0, player_x, player_y}, 64'd0);
    chk("rst_cnt", {44'b0, moves, pushes}, 64'd0);
    chk("rst_flags", {61'b0, step_done, moved, win}, 64'd0);
    chk("rst_stage", {62'b0, stage}, 64'd0);
    chk("rst_ready", {63'b0, dir_ready}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("auto_x", {61'b0, player_x}, 64'd4);
    chk("auto_y", {61'b0, player_y}, 64'd4);
    chk("auto_box", box, B0);
    chk("auto_moves", {54'b0, moves}, 64'd0);
    chk("auto_ready", {63'b0, dir_ready}, 64'd1);

    cmd(2'd0, mk(1'b1, 3'd4, 3'd3, 10'd1, 10'd0, 1'b0, B0));
    drain();
    load(2'd0, 3'd4, 3'd4, B0);
    cmd(2'd3, mk(1'b0, 3'd4, 3'd4, 10'd0, 10'd0, 1'b0, B0));
    drain();
    load(2'd0, 3'd4, 3'd4, B0);
    cmd(2'd1, mk(1'b1, 3'd4, 3'd5, 10'd1, 10'd1, 1'b0, B0P));
    cmd(2'd1, mk(1'b0, 3'd4, 3'd5, 10'd1, 10'd1, 1'b0, B0P));
    drain();

    load(2'd2, 3'd0, 3'd0, 64'h2);
    cmd(2'd0, mk(1'b0, 3'd0, 3'd0, 10'd0, 10'd0, 1'b0, 64'h2));
    cmd(2'd2, mk(1'b0, 3'd0, 3'd0, 10'd0, 10'd0, 1'b0, 64'h2));
    cmd(2'd3, mk(1'b1, 3'd1, 3'd0, 10'd1, 10'd1, 1'b1, 64'h4));
    drain();
    chk("won_ready", {63'b0, dir_ready}, 64'd0);
    chk("won_win", {63'b0, win}, 64'd1);
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      dir_valid = 1'b1;
      dir = 2'(i);
    end
    @(negedge clk);
    dir_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("won_hold_x", {61'b0, player_x}, 64'd1);
    chk("won_hold_box", box, 64'h4);
    chk("won_hold_win", {63'b0, win}, 64'd1);

    // new_game in the EVAL cycle aborts the command
    load(2'd0, 3'd4, 3'd4, B0);
    @(negedge clk);
    chk("race_ready", {63'b0, dir_ready}, 64'd1);
    dir_valid = 1'b1;
    dir = 2'd0;
    @(posedge clk);
    #1 dir_valid = 1'b0;
    new_game = 1'b1;
    level_sel = 2'd1;
    @(posedge clk);
    #1 new_game = 1'b0;
    chk("race_no_step", {63'b0, step_done}, 64'd0);
    chk("race_stage", {62'b0, stage}, 64'd1);
    @(posedge clk);
    #1;
    chk("race_x", {61'b0, player_x}, 64'd2);
    chk("race_y", {61'b0, player_y}, 64'd2);
    chk("race_box", box, B1);
    chk("race_moves", {54'b0, moves}, 64'd0);

    for (int unsigned i = 0; i < 1100; i++) begin
      yy = (i % 2 == 0) ? 3'd1 : 3'd2;
      mm = (i + 1 > 1023) ? 10'd1023 : 10'(i + 1);
      cmd((i % 2 == 0) ? 2'd0 : 2'd1, mk(1'b1, 3'd2, yy, mm, 10'd0, 1'b0, B1));
    end
    drain();
    chk("sat_moves", {54'b0, moves}, 64'd1023);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
